prog_encoder: RTL
=================

// Module: prog_encoder
// PURPOSE
//  Encoder/loader that writes programs into instruction memory. Decoded instruction fields
//  arrive on a valid/ready stream. Each is packed into a 9-bit machine word and buffered
//  in a small FIFO. Words are written sequentially from address 0. The CPU is held in init
//  throughout the load. This block produces the words that the control decoder consumes
//  (opcode in [8:6]).
// PARAMETERS
//  ADDR_W  8  instruction memory address width; capacity = 2**ADDR_W words
//  DEPTH   4  FIFO depth in words (power of 2, >=2)
// PORTS
//  clk        in   1       system clock; all state on rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  start      in   1       begin a program load (honoured only in IDLE)
//  in_valid   in   1       instruction fields valid
//  in_ready   out  1       encoder can accept fields this cycle
//  in_op      in   3       opcode_t
//  in_ra      in   3       register field A
//  in_rb      in   3       register field B (ALU ops)
//  in_imm     in   6       immediate (lw/sw: low 3 bits used; br: all 6)
//  in_last    in   1       marks final instruction of the program
//  im_we      out  1       instruction memory write strobe
//  im_ready   in   1       memory accepts the write this cycle
//  im_addr    out  ADDR_W  write address
//  im_wdata   out  9       encoded instruction word
//  cpu_init   out  1       drives the CPU init input; high while loading
//  done       out  1       one-cycle pulse when the load completes
//  range_err  out  1       sticky: lw/sw immediate exceeded 3 bits
//  overflow   out  1       sticky: program exceeded memory capacity
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, FIFO empty, im_addr=0, all outputs 0.
//  - Encoding:
//    - AND/XOR/SHL/SHR/ADD: {op, ra, rb}
//    - LW/SW: {op, ra, imm[2:0]}; if imm[5:3]!=0, set range_err and still write the truncated word
//    - BR: {op, imm[5:0]}
//  - FSM:
//    - IDLE -> LOAD on start. On this transition: clear im_addr, range_err and overflow.
//    - LOAD -> FLUSH on an accepted beat with in_last=1.
//    - FLUSH -> DONE when the FIFO is empty and no write is pending.
//    - DONE -> IDLE unconditionally. done=1 only in DONE.
//  - cpu_init=1 in LOAD and FLUSH. Otherwise 0.
//  - in_ready=1 only in LOAD with FIFO not full. A beat is accepted on in_valid && in_ready.
//  - Full FIFO: in_ready=0 even if a pop occurs in the same cycle. No same-cycle push-through.
//  - Write side: im_we/im_addr/im_wdata are registered from the FIFO head and held stable
//    while im_we=1 && im_ready=0. On im_we && im_ready: pop the FIFO, and im_addr increments
//    on the following cycle.
//  - Latency: with the FIFO empty and im_ready=1, an accepted beat appears with im_we=1 on
//    the next cycle. Throughput is 1 word/cycle sustained.
//  - Simultaneous push and pop on a non-full, non-empty FIFO: both take effect. Count is unchanged.
//  - Capacity: after word 2**ADDR_W-1 is written, im_addr saturates. Further beats are still
//    accepted (in_ready unaffected) but are dropped without im_we, and overflow is set.
//    im_addr never wraps.
//  - start outside IDLE: ignored. in_valid outside LOAD: ignored; no state change.
//  - Reset mid-load: immediate return to IDLE. FIFO contents are discarded and cpu_init=0.
//    A partially written memory is not cleaned up.
// STRUCTURE
//  - cpu_pkg (shared):
//    - opcode_t enum: AND=000 XOR=001 SHL=010 SHR=011 ADD=100 LW=101 SW=110 BR=111
//    - INSTR_W=9, OP_MSB=8, OP_LSB=6, REG_W=3, BR_IMM_W=6, MEM_IMM_W=3
//    - control and this block both import it
//  - Sub-module: sync_fifo #(WIDTH=INSTR_W, DEPTH). Ports: push/pop/full/empty/din/dout.
//  - Top level holds the encode function, the FSM, the address counter and the sticky flags.
// TESTING
//  - start, ADD ra=1 rb=2 last=1 -> one write 9'h10A @0. done pulses. cpu_init high start+1..DONE-1.
//  - LW ra=3 imm=5, then BR imm=6'h2A last -> 9'h15D @0, 9'h1EA @1. range_err=0.
//  - SW ra=2 imm=6'd9 -> word 9'h191 @0. range_err=1 until next start.
//  - im_ready=0 for 6 cycles with DEPTH=4 and back-to-back beats:
//    - in_ready drops after 4 accepts plus the registered head
//    - im_addr/im_wdata stay stable while stalled
//    - no word is lost or duplicated
//  - ADDR_W=2, 5 beats -> addresses 0..3 are written, the 5th is dropped, overflow=1.
//  - rst_n low mid-LOAD with 2 words queued:
//    - async clear: im_we=0, cpu_init=0, im_addr=0
//    - a fresh start reloads cleanly from address 0

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encoding and instruction word field geometry.
// Imported by the program encoder and the control decoder.
package cpu_pkg;

  typedef enum logic [2:0] {
    AND = 3'b000,
    XOR = 3'b001,
    SHL = 3'b010,
    SHR = 3'b011,
    ADD = 3'b100,
    LW  = 3'b101,
    SW  = 3'b110,
    BR  = 3'b111
  } opcode_t;

  localparam int INSTR_W   = 9;
  localparam int OP_MSB    = 8;
  localparam int OP_LSB    = 6;
  localparam int REG_W     = 3;
  localparam int BR_IMM_W  = 6;
  localparam int MEM_IMM_W = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-bit wrap pointers; push ignored when full, pop when empty.
// Head word is visible on dout whenever the FIFO is not empty.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/prog_encoder.sv
// Program loader: packs decoded instruction fields into 9-bit words and writes them
// sequentially into instruction memory while holding the CPU in init.
module prog_encoder
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  opcode_t             in_op,
  input  logic [REG_W-1:0]    in_ra,
  input  logic [REG_W-1:0]    in_rb,
  input  logic [BR_IMM_W-1:0] in_imm,
  input  logic                in_last,
  output logic                im_we,
  input  logic                im_ready,
  output logic [ADDR_W-1:0]   im_addr,
  output logic [INSTR_W-1:0]  im_wdata,
  output logic                cpu_init,
  output logic                done,
  output logic                range_err,
  output logic                overflow
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  function automatic logic [INSTR_W-1:0] encode(input opcode_t             op,
                                                input logic [REG_W-1:0]    ra,
                                                input logic [REG_W-1:0]    rb,
                                                input logic [BR_IMM_W-1:0] imm);
    logic [INSTR_W-1:0] w;
    w = '0;
    w[OP_MSB:OP_LSB] = op;
    case (op)
      BR: w[BR_IMM_W-1:0] = imm;
      LW, SW: begin
        w[OP_LSB-1 -: REG_W] = ra;
        w[MEM_IMM_W-1:0]     = imm[MEM_IMM_W-1:0];
      end
      default: begin
        w[OP_LSB-1 -: REG_W] = ra;
        w[REG_W-1:0]         = rb;
      end
    endcase
    return w;
  endfunction

  state_t               state_q, state_d;
  logic                 im_we_q, im_we_d;
  logic [ADDR_W-1:0]    im_addr_q, im_addr_d;
  logic [INSTR_W-1:0]   im_wdata_q, im_wdata_d;
  logic                 mem_full_q, mem_full_d;
  logic                 range_err_q, range_err_d;
  logic                 overflow_q, overflow_d;

  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [INSTR_W-1:0]   fifo_dout, enc_word, load_word;
  logic                 accept, write_fire, slot_free, load_valid, full_now;

  sync_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (enc_word),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready  = (state_q == S_LOAD) && !fifo_full;
  assign cpu_init  = (state_q == S_LOAD) || (state_q == S_FLUSH);
  assign done      = (state_q == S_DONE);
  assign im_we     = im_we_q;
  assign im_addr   = im_addr_q;
  assign im_wdata  = im_wdata_q;
  assign range_err = range_err_q;
  assign overflow  = overflow_q;

  // The output register is one extra slot in front of the FIFO; with the FIFO
  // empty an accepted beat bypasses straight into it for single-cycle latency.
  always_comb begin
    enc_word   = encode(in_op, in_ra, in_rb, in_imm);
    accept     = in_valid && in_ready;
    write_fire = im_we_q && im_ready;
    slot_free  = !im_we_q || im_ready;
    fifo_pop   = slot_free && !fifo_empty;
    fifo_push  = accept && !(slot_free && fifo_empty);
    load_valid = slot_free && (!fifo_empty || accept);
    load_word  = fifo_empty ? enc_word : fifo_dout;
    full_now   = mem_full_q || (write_fire && (im_addr_q == ADDR_MAX));
  end

  always_comb begin
    state_d     = state_q;
    im_we_d     = im_we_q;
    im_addr_d   = im_addr_q;
    im_wdata_d  = im_wdata_q;
    mem_full_d  = mem_full_q;
    range_err_d = range_err_q;
    overflow_d  = overflow_q;

    if (write_fire) begin
      if (im_addr_q == ADDR_MAX) mem_full_d = 1'b1;
      else                       im_addr_d  = im_addr_q + ADDR_W'(1);
    end

    if (slot_free) begin
      im_we_d = 1'b0;
      if (load_valid) begin
        if (full_now) begin
          overflow_d = 1'b1;
        end else begin
          im_we_d    = 1'b1;
          im_wdata_d = load_word;
        end
      end
    end

    if (accept && ((in_op == LW) || (in_op == SW)) &&
        (in_imm[BR_IMM_W-1:MEM_IMM_W] != '0))
      range_err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_LOAD;
          im_addr_d   = '0;
          mem_full_d  = 1'b0;
          range_err_d = 1'b0;
          overflow_d  = 1'b0;
        end
      end
      S_LOAD:  if (accept && in_last) state_d = S_FLUSH;
      S_FLUSH: if (fifo_empty && !im_we_q) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      im_we_q     <= 1'b0;
      im_addr_q   <= '0;
      im_wdata_q  <= '0;
      mem_full_q  <= 1'b0;
      range_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      im_we_q     <= im_we_d;
      im_addr_q   <= im_addr_d;
      im_wdata_q  <= im_wdata_d;
      mem_full_q  <= mem_full_d;
      range_err_q <= range_err_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule
